imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory write port (wr_data/wr_addr/wr_en) of the fetch stage.
//  Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words,
//  and writes them to consecutive word-aligned byte addresses starting at 0.
//  Holds the core in reset (core_hold) for the duration of a load; releases it when the load is done.
// PARAMETERS
//  WIDTH    32   bits per instruction word; fixed at 32, 4 bytes per word
//  SIZE     256  instruction memory depth in words; LOGSIZE = $clog2(SIZE)
// PORTS
//  clk         in   1            clock; single clock domain
//  reset       in   1            synchronous, active-high reset
//  start       in   1            one-cycle pulse; begins a load when IDLE
//  byte_in     in   8            stream data byte
//  byte_valid  in   1            byte_in valid
//  byte_ready  out  1            loader accepts a byte this cycle
//  wr_data     out  WIDTH        word to instruction memory
//  wr_addr     out  LOGSIZE+2    byte address, always word-aligned (bits [1:0] = 0)
//  wr_en       out  1            one-cycle write strobe
//  core_hold   out  1            high while loading; ORed into core reset externally
//  busy        out  1            high in any state except IDLE and DONE
//  done        out  1            one-cycle pulse on load completion
//  overflow    out  1            sticky; set if header word count exceeds SIZE; cleared by start or reset
// BEHAVIOUR
//  Reset: state IDLE; byte_ready, wr_en, done, busy, core_hold, overflow = 0; wr_data, wr_addr = 0.
//  Handshake: byte transferred only on a cycle where byte_valid && byte_ready; byte_in sampled then.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes.
//  States: IDLE -start-> LEN_LO -byte-> LEN_HI -byte-> (N==0 ? FINISH : DATA)
//          DATA -4*N bytes accepted-> FINISH -> DONE -start-> LEN_LO.
//  byte_ready = 1 in LEN_LO, LEN_HI, DATA; 0 in IDLE, FINISH, DONE.
//  core_hold = 1 from the cycle after start until FINISH inclusive; 0 in IDLE and DONE.
//  Packing: byte k of a word goes to wr_data[8k+7:8k]. wr_en is registered: it pulses exactly
//   the cycle after the 4th byte of a word is accepted, with wr_data/wr_addr stable that cycle.
//  Address: word j written at wr_addr = 4*j; address counter increments after each write.
//  Overflow: if N > SIZE, overflow set on LEN_HI accept; all N*4 bytes still consumed,
//   but wr_en suppressed for words j >= SIZE (no address wrap-around).
//  FINISH lasts one cycle; it waits for the final wr_en to have issued. done pulses on entry to DONE.
//  start ignored while busy. start in DONE restarts: address counter and overflow cleared.
//  Reset mid-load: abort immediately to IDLE; partially packed word discarded, no write issued.
//  Back-to-back bytes at full rate (valid held high) sustain one word per 4 cycles; no stalls.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: one extra byte after payload; it must equal XOR of all payload bytes.
//   Adds state CKSUM between DATA and FINISH (byte_ready=1) and output cksum_err (1 bit, sticky,
//   set when received byte mismatches, cleared by start/reset; N==0 still expects checksum 0x00).
//  Not defined: no CKSUM state, no cksum_err port; FINISH follows the last payload byte directly.
// STRUCTURE
//  Package loader_pkg: typedef enum loader_state_t {IDLE, LEN_LO, LEN_HI, DATA, CKSUM, FINISH, DONE};
//   localparam BYTES_PER_WORD = 4; localparam LEN_BYTES = 2.
//  Sub-module byte_packer: 2-bit byte index + 32-bit shift register; outputs word and word_done.
//  Top holds FSM, 16-bit word counter, address counter, overflow/checksum logic.
// TESTING
//  1. N=2, bytes 02 00 13 00 00 00 93 00 10 00 -> wr_en twice: (0x0, 0x00000013), (0x4, 0x00100093); done once.
//  2. N=0 (00 00) -> no wr_en; done pulses 2 cycles after LEN_HI accept; core_hold drops.
//  3. N=3, byte_valid toggled randomly -> same writes as gap-free; wr_en only the cycle after 4th byte.
//  4. SIZE=4, N=5 -> overflow=1, 4 writes at 0x0..0xC, 20 payload bytes consumed, no 5th write.
//  5. Reset asserted after 6 payload bytes -> state IDLE, 1 write at 0x0 only, outputs at reset values.
//  6. LOADER_CHECKSUM_EN, N=1, payload AA BB CC DD, cksum 0x00 -> cksum_err=0; cksum 0x01 -> cksum_err=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The stream header is a little-endian word count followed by the payload bytes.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CKSUM,
      FINISH,
      DONE
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words.
// Byte k of a word lands in bits [8k+7:8k].
// word_done_o fires combinationally on the accept that completes a word.
// On that cycle word_o already holds the complete word.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   localparam int IDX_W  = $clog2(BYTES_PER_WORD);
   localparam int WORD_W = 8 * BYTES_PER_WORD;

   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] shift_q;

   // Shift each accepted byte in from the top so the first byte ends up lowest.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (accept_i) begin
         idx_q   <= idx_q + 1'b1;
         shift_q <= {byte_i, shift_q[WORD_W-1:8]};
      end
   end

   assign word_done_o = accept_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
   assign word_o      = {byte_i, shift_q[WORD_W-1:8]};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Receives a length-prefixed byte stream and writes packed words to consecutive
// word-aligned addresses. It holds the core in reset while a load is in flight.
// Optional feature: defining LOADER_CHECKSUM_EN enables a trailing XOR checksum
// byte, the CKSUM state and the cksum_err output.
module imem_loader
   import loader_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int SIZE    = 256,
   localparam int LOGSIZE = $clog2(SIZE)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic [WIDTH-1:0]   wr_data,
   output logic [LOGSIZE+1:0] wr_addr,
   output logic               wr_en,
   output logic               core_hold,
   output logic               busy,
   output logic               done,
   output logic               overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic               cksum_err
`endif
);

   localparam int LEN_W = 8 * LEN_BYTES;
   localparam int CNT_W = LOGSIZE + 1;

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t AFTER_PAYLOAD = CKSUM;
`else
   localparam loader_state_t AFTER_PAYLOAD = FINISH;
`endif

   loader_state_t      state_q;
   logic [7:0]         lenLo_q;
   logic [LEN_W-1:0]   wordsLeft_q;
   logic [CNT_W-1:0]   addr_q;
   logic               wrEn_q;
   logic [WIDTH-1:0]   wrData_q;
   logic [LOGSIZE+1:0] wrAddr_q;
   logic               done_q;
   logic               overflow_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         cksum_q;
   logic               cksumErr_q;
`endif

   logic               loading;
   logic               accept;
   logic               packAccept;
   logic               wordDone;
   logic [31:0]        packedWord;
   logic [LEN_W-1:0]   header;

   assign loading    = (state_q != IDLE) && (state_q != DONE);
   assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CKSUM);
   assign accept     = byte_valid && byte_ready;
   assign packAccept = accept && (state_q == DATA);
   assign header     = {byte_in, lenLo_q};

   byte_packer uPacker (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (!loading),
      .accept_i   (packAccept),
      .byte_i     (byte_in),
      .word_o     (packedWord),
      .word_done_o(wordDone)
   );

   // Load sequencer with registered write strobe, done pulse and sticky status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lenLo_q     <= '0;
         wordsLeft_q <= '0;
         addr_q      <= '0;
         wrEn_q      <= 1'b0;
         wrData_q    <= '0;
         wrAddr_q    <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         cksum_q     <= '0;
         cksumErr_q  <= 1'b0;
`endif
      end else begin
         wrEn_q <= 1'b0;
         done_q <= 1'b0;

         // Words beyond the memory depth are consumed but never written, so the address cannot wrap.
         if (wordDone && (addr_q < CNT_W'(SIZE))) begin
            wrEn_q   <= 1'b1;
            wrData_q <= packedWord;
            wrAddr_q <= {addr_q[LOGSIZE-1:0], 2'b00};
            addr_q   <= addr_q + 1'b1;
         end

         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= LEN_LO;
                  addr_q     <= '0;
                  overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  cksum_q    <= '0;
                  cksumErr_q <= 1'b0;
`endif
               end
            end
            LEN_LO: begin
               if (accept) begin
                  lenLo_q <= byte_in;
                  state_q <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  wordsLeft_q <= header;
                  overflow_q  <= ({1'b0, header} > (LEN_W + 1)'(SIZE));
                  state_q     <= (header == '0) ? AFTER_PAYLOAD : DATA;
               end
            end
            DATA: begin
               if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                  cksum_q <= cksum_q ^ byte_in;
`endif
                  if (wordDone) begin
                     wordsLeft_q <= wordsLeft_q - 1'b1;
                     if (wordsLeft_q == LEN_W'(1)) begin
                        state_q <= AFTER_PAYLOAD;
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CKSUM: begin
               if (accept) begin
                  if (byte_in != cksum_q) begin
                     cksumErr_q <= 1'b1;
                  end
                  state_q <= FINISH;
               end
            end
`endif
            FINISH: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_en     = wrEn_q;
   assign wr_data   = wrData_q;
   assign wr_addr   = wrAddr_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign busy      = loading;
   assign core_hold = loading;
`ifdef LOADER_CHECKSUM_EN
   assign cksum_err = cksumErr_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (built with SIZE=4 so the overflow path is reachable).
// Each load is modelled as a list of stream bytes plus a queue of expected
// (address, data) writes derived from the payload bytes.
module tb_imem_loader;

   localparam int SIZE = 4;
   localparam int AW   = $clog2(SIZE) + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [31:0]   wr_data;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic          core_hold;
   logic          busy;
   logic          done;
   logic          overflow;
`ifdef LOADER_CHECKSUM_EN
   logic          cksum_err;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   int         vectors = 0;
   int         miscompares = 0;
   bit         lastAcc;
   logic [7:0] stream[$];
   logic [7:0] fixedPay[$];
   wr_t        expWr[$];

   imem_loader #(.WIDTH(32), .SIZE(SIZE)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .byte_in   (byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .wr_data   (wr_data),
      .wr_addr   (wr_addr),
      .wr_en     (wr_en),
      .core_hold (core_hold),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
`ifdef LOADER_CHECKSUM_EN
      ,
      .cksum_err (cksum_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the negedge, note acceptance, then move to the next negedge.
   task automatic applyStimulus(input bit v, input logic [7:0] b, input bit s);
      byte_valid = v;
      byte_in    = b;
      start      = s;
      #1;
      lastAcc = v && (byte_ready === 1'b1);
      @(negedge clk);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ready"},    byte_ready, 0);
      checkOutput({tag, "_wr_en"},    wr_en, 0);
      checkOutput({tag, "_done"},     done, 0);
      checkOutput({tag, "_busy"},     busy, 0);
      checkOutput({tag, "_hold"},     core_hold, 0);
      checkOutput({tag, "_overflow"}, overflow, 0);
      checkOutput({tag, "_wr_data"},  wr_data, 0);
      checkOutput({tag, "_wr_addr"},  wr_addr, 0);
   endtask

   // Build the stream and the expected writes.
   // Uses fixedPay when it is non-empty; otherwise payload bytes are random.
   task automatic buildStream(input int n, input bit badCk);
      logic [7:0] pay[$];
      logic [7:0] x;
      wr_t        w;
      stream.delete();
      expWr.delete();
      for (int i = 0; i < 4 * n; i++) begin
         pay.push_back((fixedPay.size() > 0) ? fixedPay[i] : 8'($urandom));
      end
      stream.push_back(8'(n % 256));
      stream.push_back(8'(n / 256));
      x = 8'h00;
      foreach (pay[i]) begin
         stream.push_back(pay[i]);
         x = x ^ pay[i];
      end
      for (int j = 0; j < n && j < SIZE; j++) begin
         w.addr = AW'(4 * j);
         w.data = {pay[4*j+3], pay[4*j+2], pay[4*j+1], pay[4*j]};
         expWr.push_back(w);
      end
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(badCk ? (x ^ 8'h01) : x);
`else
      if (badCk) begin
         $display("[TB] checksum corruption ignored without checksum build");
      end
`endif
   endtask

   // Run one load.
   // abortAfter >= 0 stops after that many payload bytes and leaves the FSM mid-load.
   task automatic runLoad(input int n, input int gapPct, input bit badCk, input int abortAfter);
      int  k;
      int  p;
      int  budget;
      bit  v;
      bit  wrExp;
      bit  aborted;
      wr_t w;
      buildStream(n, badCk);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("start_ready", byte_ready, 1);
      checkOutput("start_hold", core_hold, 1);
      checkOutput("start_busy", busy, 1);
      checkOutput("start_ovf_clear", overflow, 0);
      k = 0;
      budget = 0;
      aborted = 0;
      while (k < stream.size() && budget < 3000 && !aborted) begin
         budget++;
         v = ($urandom_range(99) >= gapPct);
         applyStimulus(v, v ? stream[k] : 8'($urandom), ($urandom_range(15) == 0));
         checkOutput("accept", lastAcc, v);
         wrExp = 0;
         if (lastAcc) begin
            p = k - 2;
            wrExp = (p >= 0) && (p < 4 * n) && (p % 4 == 3) && (p / 4 < SIZE);
            k++;
            if (k == 2) checkOutput("ovf_on_len", overflow, n > SIZE);
         end
         checkOutput("wr_en", wr_en, wrExp);
         if (wrExp && expWr.size() > 0) begin
            w = expWr.pop_front();
            checkOutput("wr_addr", wr_addr, w.addr);
            checkOutput("wr_data", wr_data, w.data);
         end
         checkOutput("done_low", done, 0);
         if (k < stream.size()) checkOutput("ready_high", byte_ready, 1);
         if (abortAfter >= 0 && k == 2 + abortAfter) aborted = 1;
      end
      checkOutput("load_budget", k, aborted ? 2 + abortAfter : stream.size());
      if (aborted) return;
      checkOutput("finish_ready", byte_ready, 0);
      checkOutput("finish_hold", core_hold, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("done_pulse", done, 1);
      checkOutput("done_hold", core_hold, 0);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_ready", byte_ready, 0);
      checkOutput("done_wr_en", wr_en, 0);
      checkOutput("done_overflow", overflow, n > SIZE);
`ifdef LOADER_CHECKSUM_EN
      checkOutput("cksum_err", cksum_err, badCk);
`endif
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("done_once", done, 0);
      checkOutput("writes_left", expWr.size(), 0);
   endtask

   // Directed sequence followed by a few randomized loads.
   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkResetValues("reset");
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);

      fixedPay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      runLoad(2, 0, 0, -1);
      fixedPay.delete();

      runLoad(0, 0, 0, -1);
      runLoad(3, 40, 0, -1);
      runLoad(5, 0, 0, -1);

      runLoad(3, 0, 0, 6);
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkResetValues("abort");
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkResetValues("abort_idle");

      fixedPay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      runLoad(2, 0, 0, -1);
      fixedPay.delete();

      for (int i = 0; i < 6; i++) begin
         runLoad($urandom_range(6), $urandom_range(50), 0, -1);
      end

`ifdef LOADER_CHECKSUM_EN
      fixedPay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      runLoad(1, 0, 0, -1);
      runLoad(1, 0, 1, -1);
      fixedPay.delete();
      runLoad(0, 0, 1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
